bin2dec_sched: RTL and testbench

Shared, sequential binary-to-7-segment conversion engine for ADC readouts. Up to `NREQ` requesters (ADC channels, UART echo path) request display of a 16-bit unsigned value. A round-robin arbiter grants one requester at a time. The granted value goes through a 16-step shift-add-3 BCD conversion, and the result drives five registered, active-low seven-segment digit outputs.

---
 rtl/bin2dec_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_bin2dec_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2dec_sched.sv
// rtl/bin2dec_sched.sv - round-robin shared binary-to-7-segment conversion engine
//
// Purpose:
//    Up to NREQ requesters ask for a 16-bit unsigned value to be displayed.
//    A round-robin arbiter grants one requester at a time. The granted value
//    is converted to BCD with a 16-step shift-add-3 sequence. The five BCD
//    digits are then encoded into registered, active-low seven-segment outputs.
//
// Configuration:
//    BIN2DEC_BLANK_EN - when defined, leading zeros on d4..d1 are blanked (7'h7F).
//                       d0 always shows its digit.
//
// Ports:
//    clk_i            system clock, rising edge
//    rst_i            asynchronous active-high reset
//    req_i  [NREQ]    per-requester request, held until the matching ack
//    data_i [16*NREQ] requester k value on bits [16k+15:16k]
//    ack_o  [NREQ]    one-cycle pulse to the served requester, digits valid with it
//    busy_o           conversion in flight
//    sel_o  [3]       granted / most recently served requester
//    d0_o..d4_o [7]   segments gfedcba, active-low, d0 least significant

module bin2dec_sched #(
   parameter int NREQ = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [16*NREQ-1:0]   data_i,
   output logic [NREQ-1:0]      ack_o,
   output logic                 busy_o,
   output logic [2:0]           sel_o,
   output logic [6:0]           d0_o,
   output logic [6:0]           d1_o,
   output logic [6:0]           d2_o,
   output logic [6:0]           d3_o,
   output logic [6:0]           d4_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_ENCODE,
      S_DONE
   } state_t;

`ifdef BIN2DEC_BLANK_EN
   localparam logic [6:0] LEAD_RST = 7'h7F;
`else
   localparam logic [6:0] LEAD_RST = 7'h40;
`endif

   state_t            state_q;
   logic [2:0]        ptr_q;
   logic [2:0]        sel_q;
   logic              busy_q;
   logic [NREQ-1:0]   ack_q;
   logic [15:0]       bin_q;
   logic [19:0]       bcd_q;
   logic [3:0]        cnt_q;
   logic [6:0]        d0_q, d1_q, d2_q, d3_q, d4_q;

   logic              found_d;
   logic [2:0]        win_d;
   logic [2:0]        ptr_d;
   logic [15:0]       data_sel_d;
   logic [19:0]       bcd_adj_d;
   logic [6:0]        d0_d, d1_d, d2_d, d3_d, d4_d;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Round-robin pick: first set request at or above ptr_q, wrapping around.
   always_comb begin
      int idx;
      found_d = 1'b0;
      win_d   = 3'd0;
      idx     = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found_d && req_i[idx]) begin
            found_d = 1'b1;
            win_d   = 3'(idx);
         end
      end
      ptr_d = (win_d == 3'(NREQ - 1)) ? 3'd0 : win_d + 3'd1;
   end

   always_comb begin
      data_sel_d = 16'd0;
      for (int k = 0; k < NREQ; k++) begin
         if (sel_q == 3'(k)) begin
            data_sel_d = data_i[16*k +: 16];
         end
      end
   end

   // Add-3 correction applied to every nibble before the shift.
   always_comb begin
      logic [3:0] nib;
      bcd_adj_d = bcd_q;
      nib       = 4'd0;
      for (int i = 0; i < 5; i++) begin
         nib = bcd_q[4*i +: 4];
         bcd_adj_d[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   end

   always_comb begin
      logic blank1, blank2, blank3, blank4;
`ifdef BIN2DEC_BLANK_EN
      // A digit blanks only when it and every more significant digit are zero.
      blank4 = (bcd_q[19:16] == 4'd0);
      blank3 = (bcd_q[19:12] == 8'd0);
      blank2 = (bcd_q[19:8]  == 12'd0);
      blank1 = (bcd_q[19:4]  == 16'd0);
`else
      blank4 = 1'b0;
      blank3 = 1'b0;
      blank2 = 1'b0;
      blank1 = 1'b0;
`endif
      d0_d = seg7(bcd_q[3:0]);
      d1_d = blank1 ? 7'h7F : seg7(bcd_q[7:4]);
      d2_d = blank2 ? 7'h7F : seg7(bcd_q[11:8]);
      d3_d = blank3 ? 7'h7F : seg7(bcd_q[15:12]);
      d4_d = blank4 ? 7'h7F : seg7(bcd_q[19:16]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ptr_q   <= 3'd0;
         sel_q   <= 3'd0;
         busy_q  <= 1'b0;
         ack_q   <= '0;
         bin_q   <= 16'd0;
         bcd_q   <= 20'd0;
         cnt_q   <= 4'd0;
         d0_q    <= 7'h40;
         d1_q    <= LEAD_RST;
         d2_q    <= LEAD_RST;
         d3_q    <= LEAD_RST;
         d4_q    <= LEAD_RST;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  sel_q   <= win_d;
                  busy_q  <= 1'b1;
                  ptr_q   <= ptr_d;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               bin_q   <= data_sel_d;
               bcd_q   <= 20'd0;
               cnt_q   <= 4'd0;
               state_q <= S_SHIFT;
            end
            S_SHIFT: begin
               bcd_q <= {bcd_adj_d[18:0], bin_q[15]};
               bin_q <= {bin_q[14:0], 1'b0};
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_q <= S_ENCODE;
               end
            end
            S_ENCODE: begin
               d0_q <= d0_d;
               d1_q <= d1_d;
               d2_q <= d2_d;
               d3_q <= d3_d;
               d4_q <= d4_d;
               for (int k = 0; k < NREQ; k++) begin
                  ack_q[k] <= (sel_q == 3'(k));
               end
               state_q <= S_DONE;
            end
            S_DONE: begin
               ack_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ack_o  = ack_q;
   assign busy_o = busy_q;
   assign sel_o  = sel_q;
   assign d0_o   = d0_q;
   assign d1_o   = d1_q;
   assign d2_o   = d2_q;
   assign d3_o   = d3_q;
   assign d4_o   = d4_q;

endmodule

// File: tb/tb_bin2dec_sched.sv
// tb/tb_bin2dec_sched.sv - self-checking bench for bin2dec_sched

module tb_bin2dec_sched;

   localparam int NREQ = 4;

`ifdef BIN2DEC_BLANK_EN
   localparam logic [31:0] LZ = 32'h7F;
`else
   localparam logic [31:0] LZ = 32'h40;
`endif

   localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   localparam logic [31:0] RR_D0 [4] = '{32'h79, 32'h24, 32'h30, 32'h19};

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [16*NREQ-1:0]   data;
   logic [NREQ-1:0]      ack_o;
   logic                 busy_o;
   logic [2:0]           sel_o;
   logic [6:0]           d0_o, d1_o, d2_o, d3_o, d4_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n, c, ca, cb, prev;

   bin2dec_sched #(.NREQ(NREQ)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (req),
      .data_i (data),
      .ack_o  (ack_o),
      .busy_o (busy_o),
      .sel_o  (sel_o),
      .d0_o   (d0_o),
      .d1_o   (d1_o),
      .d2_o   (d2_o),
      .d3_o   (d3_o),
      .d4_o   (d4_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected segment pattern for decimal digit position i of value v.
   function automatic logic [6:0] exp_seg(input int v, input int i);
      int p;
      int dg;
      p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      dg = (v / p) % 10;
`ifdef BIN2DEC_BLANK_EN
      if (i > 0 && v < p) return 7'h7F;
`endif
      return SEG_TAB[dg];
   endfunction

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   // Reference model: a grant starts a fixed 20-cycle service window.
   int              m_phase;
   int              m_ptr;
   int              m_sel;
   int              m_val;
   logic            m_busy;
   logic [NREQ-1:0] m_ack;
   logic [6:0]      m_d [5];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0;
         m_ptr   <= 0;
         m_sel   <= 0;
         m_busy  <= 1'b0;
         m_ack   <= '0;
         m_d[0]  <= 7'h40;
         for (int i = 1; i < 5; i++) m_d[i] <= LZ[6:0];
      end else if (m_phase == 0) begin
         if (pick(req, m_ptr) >= 0) begin
            m_sel   <= pick(req, m_ptr);
            m_ptr   <= (pick(req, m_ptr) + 1) % NREQ;
            m_busy  <= 1'b1;
            m_phase <= 1;
         end
      end else if (m_phase == 19) begin
         m_ack   <= '0;
         m_busy  <= 1'b0;
         m_phase <= 0;
      end else begin
         if (m_phase == 1) m_val <= int'(data[16*m_sel +: 16]);
         if (m_phase == 18) begin
            for (int i = 0; i < 5; i++) m_d[i] <= exp_seg(m_val, i);
            m_ack <= 4'(1 << m_sel);
         end
         m_phase <= m_phase + 1;
      end
   end

   always @(negedge clk) begin
      check("ack",  32'(ack_o),  32'(m_ack));
      check("busy", 32'(busy_o), 32'(m_busy));
      check("sel",  32'(sel_o),  m_sel);
      check("d0",   32'(d0_o),   32'(m_d[0]));
      check("d1",   32'(d1_o),   32'(m_d[1]));
      check("d2",   32'(d2_o),   32'(m_d[2]));
      check("d3",   32'(d3_o),   32'(m_d[3]));
      check("d4",   32'(d4_o),   32'(m_d[4]));
   end

   task automatic wait_ack(input int k, output int c_out);
      int cnt;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!ack_o[k] && cnt < 100);
      check("ack_seen", 32'(ack_o[k]), 32'd1);
      c_out = cyc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst  = 1'b1;
      req  = '0;
      data = '0;
      data[15:0]  = 16'd1;
      data[31:16] = 16'd22;
      data[47:32] = 16'd333;
      data[63:48] = 16'd4444;
      req = 4'hF;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_ack",  32'(ack_o),  32'd0);
      check("rst_sel",  32'(sel_o),  32'd0);
      check("rst_d0",   32'(d0_o),   32'h40);
      check("rst_d4",   32'(d4_o),   LZ);
      rst = 1'b0;

      // Round robin from reset.
      prev = 0;
      for (int e = 0; e < 4; e++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (ack_o == '0 && n < 100);
         check("rr_ack", 32'(ack_o), 32'(1 << e));
         check("rr_sel", 32'(sel_o), e);
         check("rr_d0",  32'(d0_o),  RR_D0[e]);
         if (e > 0) check("rr_gap", cyc - prev, 20);
         prev = cyc;
         req[e] = 1'b0;
      end
      check("rr_d3", 32'(d3_o), 32'h19);
      check("rr_d1_of_1", 32'(d1_o), 32'h19);
      repeat (3) @(negedge clk);

      // Single request 12345 on ch0.
      data[15:0] = 16'd12345;
      req[0] = 1'b1;
      c = cyc;
      wait_ack(0, ca);
      check("single_lat", ca - c, 19);
      check("single_d4", 32'(d4_o), 32'h79);
      check("single_d3", 32'(d3_o), 32'h24);
      check("single_d2", 32'(d2_o), 32'h30);
      check("single_d1", 32'(d1_o), 32'h19);
      check("single_d0", 32'(d0_o), 32'h12);
      req[0] = 1'b0;
      @(negedge clk);
      check("single_pulse", 32'(ack_o), 32'd0);
      repeat (2) @(negedge clk);

      // Value 0 then 65535 on ch2.
      data[47:32] = 16'd0;
      req[2] = 1'b1;
      wait_ack(2, ca);
      req[2] = 1'b0;
      check("zero_d0", 32'(d0_o), 32'h40);
      check("zero_d1", 32'(d1_o), LZ);
      check("zero_d4", 32'(d4_o), LZ);
      repeat (2) @(negedge clk);
      data[47:32] = 16'd65535;
      req[2] = 1'b1;
      wait_ack(2, ca);
      req[2] = 1'b0;
      check("max_d4", 32'(d4_o), 32'h02);
      check("max_d3", 32'(d3_o), 32'h12);
      check("max_d2", 32'(d2_o), 32'h12);
      check("max_d1", 32'(d1_o), 32'h30);
      check("max_d0", 32'(d0_o), 32'h12);
      repeat (2) @(negedge clk);

      // Pointer wrap: ch3 alone, then ch0 and ch3 together.
      req[3] = 1'b1;
      wait_ack(3, ca);
      req[3] = 1'b0;
      repeat (2) @(negedge clk);
      data[15:0]  = 16'd7;
      data[63:48] = 16'd8;
      req = 4'b1001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack_o == '0 && n < 100);
      check("wrap_first", 32'(ack_o), 32'h1);
      check("wrap_first_d0", 32'(d0_o), 32'h78);
      req[0] = 1'b0;
      wait_ack(3, cb);
      check("wrap_second_d0", 32'(d0_o), 32'h00);
      req[3] = 1'b0;
      repeat (2) @(negedge clk);

      // Held request with data changed during SHIFT.
      data[31:16] = 16'd111;
      req[1] = 1'b1;
      c = cyc;
      repeat (5) @(negedge clk);
      data[31:16] = 16'd222;
      wait_ack(1, ca);
      check("hold_lat", ca - c, 19);
      check("hold_first_d2", 32'(d2_o), 32'h79);
      check("hold_first_d0", 32'(d0_o), 32'h79);
      wait_ack(1, cb);
      check("hold_gap", cb - ca, 20);
      check("hold_second_d2", 32'(d2_o), 32'h24);
      check("hold_second_d0", 32'(d0_o), 32'h24);
      req[1] = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in the middle of a conversion.
      data[47:32] = 16'd999;
      req[2] = 1'b1;
      c = cyc;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      req[2] = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_ack",  32'(ack_o),  32'd0);
      check("mid_rst_d0",   32'(d0_o),   32'h40);
      check("mid_rst_d2",   32'(d2_o),   LZ);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("mid_rst_no_ack_d0", 32'(d0_o), 32'h40);
      req[2] = 1'b1;
      c = cyc;
      wait_ack(2, ca);
      req[2] = 1'b0;
      check("rereq_lat", ca - c, 19);
      check("rereq_d2", 32'(d2_o), 32'h10);
      check("rereq_d0", 32'(d0_o), 32'h10);
      check("rereq_sel", 32'(sel_o), 32'd2);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
